// File: rtl/nibble_serial_tx.sv
// Nibble serial transmitter: start bit, din[0]..din[3], optional even parity, stop bit.
// Optional parity bit is enabled by defining NIBBLE_TX_PARITY_EN.
module nibble_serial_tx #(
  parameter int BIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:3] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [7:0] LP_LAST = 8'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef NIBBLE_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } t_state;

  t_state     r_state;
  t_state     w_state_next;
  logic [0:3] r_shift;
  logic [0:3] w_shift_next;
  logic [7:0] r_timer;
  logic [7:0] w_timer_next;
  logic [1:0] r_idx;
  logic [1:0] w_idx_next;
  logic       r_tx;
  logic       w_tx_next;
  logic       r_ready;
  logic       w_ready_next;
  logic       r_busy;
  logic       w_busy_next;
  logic       r_done;
  logic       w_done_next;

  logic       w_expire;
  logic [1:0] w_idx_inc;
  logic [7:0] w_timer_inc;

  assign w_expire    = (r_timer == LP_LAST);
  assign w_idx_inc   = r_idx + 2'd1;
  assign w_timer_inc = r_timer + 8'd1;

  // Every output is the registered value chosen one cycle earlier, so din and
  // din_valid never reach an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= 4'b0000;
      r_timer <= 8'd0;
      r_idx   <= 2'd0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_timer <= w_timer_next;
      r_idx   <= w_idx_next;
      r_tx    <= w_tx_next;
      r_ready <= w_ready_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_timer_next = r_timer;
    w_idx_next   = r_idx;
    w_tx_next    = r_tx;
    w_ready_next = r_ready;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (din_valid && r_ready) begin
          w_state_next = S_START;
          w_shift_next = din;
          w_timer_next = 8'd0;
          w_idx_next   = 2'd0;
          w_tx_next    = 1'b0;
          w_ready_next = 1'b0;
          w_busy_next  = 1'b1;
        end
      end

      S_START: begin
        if (w_expire) begin
          w_state_next = S_DATA;
          w_timer_next = 8'd0;
          w_idx_next   = 2'd0;
          w_tx_next    = r_shift[0];
        end else begin
          w_timer_next = w_timer_inc;
        end
      end

      S_DATA: begin
        if (w_expire) begin
          w_timer_next = 8'd0;
          if (r_idx == 2'd3) begin
            w_idx_next = 2'd0;
`ifdef NIBBLE_TX_PARITY_EN
            w_state_next = S_PARITY;
            w_tx_next    = ^r_shift;
`else
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_idx_next = w_idx_inc;
            w_tx_next  = r_shift[w_idx_inc];
          end
        end else begin
          w_timer_next = w_timer_inc;
        end
      end

`ifdef NIBBLE_TX_PARITY_EN
      S_PARITY: begin
        if (w_expire) begin
          w_state_next = S_STOP;
          w_timer_next = 8'd0;
          w_tx_next    = 1'b1;
        end else begin
          w_timer_next = w_timer_inc;
        end
      end
`endif

      S_STOP: begin
        if (w_expire) begin
          w_state_next = S_IDLE;
          w_timer_next = 8'd0;
          w_tx_next    = 1'b1;
          w_ready_next = 1'b1;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
        end else begin
          w_timer_next = w_timer_inc;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_timer_next = 8'd0;
        w_idx_next   = 2'd0;
        w_tx_next    = 1'b1;
        w_ready_next = 1'b1;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  assign tx         = r_tx;
  assign din_ready  = r_ready;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: doc/nibble_serial_tx.md
Name: nibble_serial_tx

Overview:
- Transmit end of the nibble bit-stream interface: accepts a 4-bit word on a valid/ready handshake and shifts it onto a single serial line, one bit period at a time, framed by start and stop bits.
- Bit index 0 goes first, matching the downstream sampler, which samples index 0 on each rising clk edge.
- Sits between the nibble source (counter or stimulus sequencer) and the serial receiver.

Parameters:
- BIT_CYCLES, 1, clk cycles each serial bit is held on tx; legal range 1..256; internal bit-timer is 8 bits wide.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- din  input  [0:3]  word to send; din[0] is transmitted first
- din_valid  input  1  source has a word on din
- din_ready  output  1  block can accept a word this cycle
- tx  output  1  serial line; idles high
- busy  output  1  frame in progress (any state other than IDLE)
- frame_done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Reset values (asynchronous, while rst=1): state=IDLE, tx=1, din_ready=1, busy=0, frame_done=0, shift register=0, bit-timer=0, bit index=0.
- All outputs are registered; no combinational path from din or din_valid to any output.
- Handshake:
  - A transfer occurs on the rising edge where din_valid=1 and din_ready=1.
  - din_ready=1 only in IDLE.
  - din is latched into the shift register on the accepting edge.
  - din/din_valid changes while busy=1 are ignored.
- States: IDLE -> START -> DATA -> (PARITY, only when the optional feature is enabled) -> STOP -> IDLE.
  - IDLE: tx=1. On transfer: go to START, tx=0, din_ready=0, busy=1, all on the same edge.
  - START: hold tx=0 for BIT_CYCLES cycles, then go to DATA with tx=din[0].
  - DATA: 4 bits, din[0]..din[3], each held BIT_CYCLES cycles. After bit index 3 expires, go to the next state.
  - STOP: hold tx=1 for BIT_CYCLES cycles. On expiry: go to IDLE, frame_done=1 for exactly one cycle, busy=0, din_ready=1.
- Timing:
  - Frame length = 6*BIT_CYCLES cycles from the accepting edge to the frame_done edge.
  - Minimum gap between frames is 1 clk cycle in IDLE, because din_ready rises on the frame_done edge and the next transfer can occur on the following edge.
- Bit timer:
  - Counts 0..BIT_CYCLES-1 and wraps to 0 at each bit boundary.
  - For BIT_CYCLES=1, tx changes every cycle.
- Reset mid-frame: the frame is aborted immediately; tx=1 asynchronously; the word is dropped; no frame_done pulse.
- din containing x/z at accept: passed through unchanged (no checking).

Optional Feature:
- Macro: NIBBLE_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after DATA. tx = even parity = din[0]^din[1]^din[2]^din[3] of the latched word, held BIT_CYCLES cycles.
  - Frame length = 7*BIT_CYCLES.
- Undefined: no PARITY state; frame length = 6*BIT_CYCLES.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release, din_valid=0 for 10 cycles -> tx=1, din_ready=1, busy=0, frame_done=0 throughout.
- Single frame: BIT_CYCLES=1, din=4'b0001 (din[3]=1), din_valid for 1 cycle -> tx on the following edges 0,0,0,0,1,1; frame_done pulses on the 6th edge after accept; din_ready=1 again on that same edge.
- Stretched bits: BIT_CYCLES=3, din=4'b1010 -> tx = 0 for 3 cycles, then 1,0,1,0 for 3 cycles each, then 1 for 3 cycles; frame_done exactly 18 cycles after accept.
- Back-to-back with busy-time noise: din_valid held high while din counts 0000..1111 -> words accepted only in IDLE; each accepted word transmitted intact; exactly 1 idle cycle (tx=1) between frames; no word corrupted by din changes while busy.
- Reset mid-frame: assert rst during DATA bit 2 -> tx=1 and busy=0 immediately (before the next edge); no frame_done pulse; next frame after release is transmitted correctly.
- With NIBBLE_TX_PARITY_EN, BIT_CYCLES=1:
  - din=4'b0111 -> tx 0,0,1,1,1,1(parity),1(stop); frame_done 7 cycles after accept.
  - din=4'b0101 -> parity bit 0.
